// File: rtl/idex_stage.sv
// idex_stage: ID/EX pipeline register of the five-stage core.
//
// Captures the decoded control fields and operands from the decode stage
// on every edge. Rs2 takes the write-back value when the forwarding unit
// asks for it. Load-use stalls and memory holds freeze the register, and
// branch flushes insert a bubble.
//
// Per-cycle action, highest priority first:
//   1. Mem_Hold  : HOLD   (registers and counters keep their value)
//   2. EX__Flush : BUBBLE (every IDex__* field and IDex__Valid load 0)
//   3. Need_Stall: HOLD   (the stalled instruction is evaluated again)
//   4. otherwise : LOAD   (capture every ID__* field)
//
// Handshake: there is no valid/ready pair. Stall_Up is the upstream
// "not ready" signal and is combinational. While it is high, the PC and the
// IF/ID register must keep their contents. When a flush wins over a
// load-use stall, Stall_Up stays low so that upstream loads the branch
// target.
//
// Ports:
//   clk, rst (async, active-low)
//   ID__*            decoded fields from the decode stage
//   WB__Data/OP2_IdS write-back value and its Rs2 select
//   Need_Stall, Mem_Hold, EX__Flush : pipeline control
//   IDex__*          registered copies (Rd1 -> OpA, muxed Rd2 -> OpB)
//   Stall_Up         combinational upstream freeze
//   Stall_Cnt, Flush_Cnt : saturating event counters
//   dbg_state        control state (0 = RUN, 1 = STALLED)
module idex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ID__PC,
  input  logic [DATA_W-1:0] ID__Imm,
  input  logic [DATA_W-1:0] ID__Rd1,
  input  logic [DATA_W-1:0] ID__Rd2,
  input  logic [DATA_W-1:0] WB__Data,
  input  logic [4:0]        ID__Rs1,
  input  logic [4:0]        ID__Rs2,
  input  logic [4:0]        ID__Rdst,
  input  logic              ID__Need_Rs1,
  input  logic              ID__Need_Rs2,
  input  logic              ID__R_WE,
  input  logic              ID__MemEnable,
  input  logic              ID__RW_MEM,
  input  logic [1:0]        ID__RDst_S,
  input  logic [3:0]        ID__ALU_Op,
  input  logic              ID__Valid,
  input  logic              OP2_IdS,
  input  logic              Need_Stall,
  input  logic              Mem_Hold,
  input  logic              EX__Flush,
  output logic [DATA_W-1:0] IDex__PC,
  output logic [DATA_W-1:0] IDex__Imm,
  output logic [DATA_W-1:0] IDex__OpA,
  output logic [DATA_W-1:0] IDex__OpB,
  output logic [4:0]        IDex__Rs1,
  output logic [4:0]        IDex__Rs2,
  output logic [4:0]        IDex__Rdst,
  output logic              IDex__Need_Rs1,
  output logic              IDex__Need_Rs2,
  output logic              IDex__R_WE,
  output logic              IDex__MemEnable,
  output logic              IDex__RW_MEM,
  output logic [1:0]        IDex__RDst_S,
  output logic [3:0]        IDex__ALU_Op,
  output logic              IDex__Valid,
  output logic              Stall_Up,
  output logic [CNT_W-1:0]  Stall_Cnt,
  output logic [CNT_W-1:0]  Flush_Cnt,
  output logic              dbg_state
);

  typedef enum logic {RUN = 1'b0, STALLED = 1'b1} ctl_state_t;

  ctl_state_t state, state_nxt;

  logic do_load;
  logic do_bubble;
  logic stall_inc;
  logic flush_inc;

  // A flush cancels the load-use freeze because the stalled instruction
  // is on the wrong path.
  assign Stall_Up  = Mem_Hold | (Need_Stall & ~EX__Flush);
  assign do_bubble = ~Mem_Hold & EX__Flush;
  assign do_load   = ~Mem_Hold & ~EX__Flush & ~Need_Stall;
  assign stall_inc = ~Mem_Hold & Need_Stall & ~EX__Flush;
  assign flush_inc = ~Mem_Hold & EX__Flush;

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (stall_inc) state_nxt = STALLED;
      STALLED: if (!Mem_Hold && (EX__Flush || !Need_Stall)) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      IDex__PC        <= '0;
      IDex__Imm       <= '0;
      IDex__OpA       <= '0;
      IDex__OpB       <= '0;
      IDex__Rs1       <= '0;
      IDex__Rs2       <= '0;
      IDex__Rdst      <= '0;
      IDex__Need_Rs1  <= 1'b0;
      IDex__Need_Rs2  <= 1'b0;
      IDex__R_WE      <= 1'b0;
      IDex__MemEnable <= 1'b0;
      IDex__RW_MEM    <= 1'b0;
      IDex__RDst_S    <= '0;
      IDex__ALU_Op    <= '0;
      IDex__Valid     <= 1'b0;
    end else if (do_bubble) begin
      IDex__PC        <= '0;
      IDex__Imm       <= '0;
      IDex__OpA       <= '0;
      IDex__OpB       <= '0;
      IDex__Rs1       <= '0;
      IDex__Rs2       <= '0;
      IDex__Rdst      <= '0;
      IDex__Need_Rs1  <= 1'b0;
      IDex__Need_Rs2  <= 1'b0;
      IDex__R_WE      <= 1'b0;
      IDex__MemEnable <= 1'b0;
      IDex__RW_MEM    <= 1'b0;
      IDex__RDst_S    <= '0;
      IDex__ALU_Op    <= '0;
      IDex__Valid     <= 1'b0;
    end else if (do_load) begin
      IDex__PC        <= ID__PC;
      IDex__Imm       <= ID__Imm;
      IDex__OpA       <= ID__Rd1;
      IDex__OpB       <= OP2_IdS ? WB__Data : ID__Rd2;
      IDex__Rs1       <= ID__Rs1;
      IDex__Rs2       <= ID__Rs2;
      IDex__Rdst      <= ID__Rdst;
      IDex__Need_Rs1  <= ID__Need_Rs1;
      IDex__Need_Rs2  <= ID__Need_Rs2;
      IDex__R_WE      <= ID__R_WE;
      IDex__MemEnable <= ID__MemEnable;
      IDex__RW_MEM    <= ID__RW_MEM;
      IDex__RDst_S    <= ID__RDst_S;
      IDex__ALU_Op    <= ID__ALU_Op;
      IDex__Valid     <= ID__Valid;
    end
  end

  // Counters saturate at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Stall_Cnt <= '0;
      Flush_Cnt <= '0;
    end else begin
      if (stall_inc && (Stall_Cnt != '1)) Stall_Cnt <= Stall_Cnt + CNT_W'(1);
      if (flush_inc && (Flush_Cnt != '1)) Flush_Cnt <= Flush_Cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/idex_stage.md
# idex_stage

ID/EX pipeline register of the 3PA five-stage core, between the decode stage and the execute stage that the forwarding unit serves. Captures decoded control and operands each cycle and applies the decode-stage Rs2 write-back forward selected by `OP2_IdS`. On load-use stalls and memory holds it freezes its contents; on branch flushes it inserts a bubble. It drives the upstream freeze and keeps saturating stall and flush counters.

## Interface
- `DATA_W`, default 32: operand, immediate and PC width.
- `CNT_W`, default 16: width of each event counter.

- `clk`  in  1  clock; every register updates on the rising edge.
- `rst`  in  1  asynchronous reset, active-low: 0 resets immediately, release is synchronous to `clk`.
- `ID__PC`, `ID__Imm`  in  DATA_W each  decoded PC and immediate.
- `ID__Rd1`, `ID__Rd2`  in  DATA_W each  register-file read data.
- `WB__Data`  in  DATA_W  write-back result, used when `OP2_IdS`=1.
- `ID__Rs1`, `ID__Rs2`, `ID__Rdst`  in  5 each  register indices.
- `ID__Need_Rs1`, `ID__Need_Rs2`, `ID__R_WE`, `ID__MemEnable`, `ID__RW_MEM`  in  1 each  decoded control bits.
- `ID__RDst_S`  in  2  write-back source select; 2'b00 = memory.
- `ID__ALU_Op`  in  4  ALU operation.
- `ID__Valid`  in  1  decode stage holds a real instruction.
- `OP2_IdS`  in  1  from the forwarding unit; 1 selects `WB__Data` for the captured `OpB`.
- `Need_Stall`  in  1  load-use stall from the forwarding unit.
- `Mem_Hold`  in  1  global freeze from the data-memory interface.
- `EX__Flush`  in  1  taken branch or jump resolved in EX.
- `IDex__*`  out  one registered copy of each `ID__*` field, same widths. `IDex__OpA` = captured `ID__Rd1`; `IDex__OpB` = captured, muxed Rs2 operand.
- `IDex__Valid`  out  1  registered valid.
- `Stall_Up`  out  1  combinational; freezes the PC and the IF/ID register.
- `Stall_Cnt`, `Flush_Cnt`  out  CNT_W each  saturating event counters.

## Operation
- Per-cycle action, highest priority first:
  - `rst`=0: clear all outputs.
  - `Mem_Hold`=1: HOLD, all registers keep their value.
  - `EX__Flush`=1: BUBBLE, all `IDex__*` fields and `IDex__Valid` load 0.
  - `Need_Stall`=1: HOLD; the stalled instruction stays in ID/EX for re-evaluation.
  - Otherwise: LOAD, capture all `ID__*` fields.
- LOAD operands:
  - `IDex__OpB` = `OP2_IdS` ? `WB__Data` : `ID__Rd2`.
  - `IDex__OpA` = `ID__Rd1`.
  - No other forwarding is done here; EX-stage forwarding belongs to the execute stage.
- A flush with `Need_Stall`=1 gives BUBBLE. The stalled instruction is squashed because it is on the wrong path.
- `Stall_Up` = `Mem_Hold` | (`Need_Stall` & ~`EX__Flush`). When a flush wins, upstream must load the branch target, not freeze.
- Counter updates, when `Mem_Hold`=0:
  - `Stall_Cnt` +1 in a cycle with `Need_Stall`=1 and `EX__Flush`=0.
  - `Flush_Cnt` +1 in a cycle with `EX__Flush`=1.
  - Both saturate at 2^CNT_W−1 and never wrap.
  - Neither counts while `Mem_Hold`=1.
- Control-state view, two implicit states:
  - RUN → STALLED on `Need_Stall` with no flush or hold.
  - STALLED → RUN when `Need_Stall` falls; the next LOAD takes the instruction waiting in IF/ID.
  - STALLED → RUN also on `EX__Flush` (bubble).

## Timing
- LOAD, BUBBLE and counter updates take effect at the rising edge after the inputs are sampled: 1-cycle latency.
- `Stall_Up` has zero latency (same-cycle combinational).
- Reset is asynchronous. While `rst`=0, every `IDex__*` output, `IDex__Valid`, `Stall_Cnt` and `Flush_Cnt` read 0, even with no `clk` edge.
- `Stall_Up` follows its inputs during reset.
- Reset mid-stall or mid-hold discards all state. The first edge after release performs a normal priority evaluation.
- A load-use stall lasts exactly as long as `Need_Stall` is high. A typical single load-use stall holds for 1 cycle, then LOADs.
- `OP2_IdS` and `WB__Data` are sampled only on LOAD edges.

## Test plan
- Reset: drive fields to nonzero, pulse `rst`=0 between edges → all outputs 0 immediately; counters 0.
- Plain load: `ID__PC`=0x100, `ID__Rd2`=0x5, `OP2_IdS`=0 → next edge `IDex__PC`=0x100, `IDex__OpB`=0x5, `IDex__Valid`=1. Repeat with `OP2_IdS`=1, `WB__Data`=0xAA → `IDex__OpB`=0xAA.
- Load-use stall:
  - Stimulus: `Need_Stall`=1 for 1 cycle, new `ID__PC`=0x104 on input.
  - Response: `Stall_Up`=1 that cycle; `IDex__PC` stays 0x100; `Stall_Cnt`=1; next cycle loads 0x104.
- Flush vs stall: `EX__Flush`=1 with `Need_Stall`=1 → `IDex__Valid`=0, `IDex__R_WE`=0, `Stall_Up`=0, `Flush_Cnt`=1, `Stall_Cnt` unchanged.
- Memory hold: `Mem_Hold`=1 for 3 cycles with `EX__Flush`=1 → contents and counters unchanged, `Stall_Up`=1; the flush is applied on the first edge after the hold drops, if still asserted.
- Saturation: CNT_W=4, `Need_Stall`=1 for 20 cycles → `Stall_Cnt` reaches 15 and stays 15.
